cva6_lsu_issue_queue: RTL

In-order issue queue directly upstream of the CVA6 LSU shim/model. Buffers memory instructions from decode and presents them one at a time to the LSU (`instr_i`, `is_load_i`, `instr_valid_i`). It tracks one outstanding load and one outstanding store using the LSU memory-response strobes, and holds a load behind an outstanding store to the same address.

---
 rtl/cva6_lsu_issue_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/cva6_lsu_issue_queue.sv
// In-order LSU issue queue: buffers decode entries and issues one per cycle to the LSU,
// holding a load behind an outstanding store to the same address. Optional macro: LSU_IQ_BYPASS_EN.
module cva6_lsu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [INSTR_W-1:0]         enq_instr_i,
  input  logic                       enq_is_load_i,
  input  logic                       lsu_ready_i,
  output logic [INSTR_W-1:0]         instr_o,
  output logic                       is_load_o,
  output logic                       instr_valid_o,
  input  logic                       load_mem_resp_i,
  input  logic                       store_mem_resp_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [DEPTH-1:0]   ld_mem_q, ld_mem_d;

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ld_busy_q, ld_busy_d, st_busy_q, st_busy_d;
  logic [INSTR_W-1:0] st_addr_q, st_addr_d;
  logic               valid_out_q, valid_out_d, is_load_out_q, is_load_out_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;

  logic               head_is_load, head_blocked, issue, bypass, enq_fire;
  logic               iss_valid, iss_is_load;
  logic [INSTR_W-1:0] head_instr, iss_instr;

  assign head_is_load = ld_mem_q[head_q];
  assign head_instr   = instr_mem_q[head_q];
  assign head_blocked = head_is_load ? (ld_busy_q || (st_busy_q && head_instr == st_addr_q))
                                     : st_busy_q;
  assign issue        = (count_q != '0) && lsu_ready_i && !head_blocked;
  assign enq_ready_o  = count_q < CNT_W'(DEPTH);

`ifdef LSU_IQ_BYPASS_EN
  // Only an empty queue may bypass: the output register carries a single issue per cycle.
  logic in_blocked;
  assign in_blocked = enq_is_load_i ? (ld_busy_q || (st_busy_q && enq_instr_i == st_addr_q))
                                    : st_busy_q;
  assign bypass     = (count_q == '0) && enq_valid_i && lsu_ready_i && !in_blocked;
`else
  assign bypass     = 1'b0;
`endif

  assign enq_fire    = enq_valid_i && enq_ready_o && !bypass;
  assign iss_valid   = issue || bypass;
  assign iss_is_load = issue ? head_is_load : enq_is_load_i;
  assign iss_instr   = issue ? head_instr : enq_instr_i;

  always_comb begin
    instr_mem_d = instr_mem_q;
    ld_mem_d    = ld_mem_q;
    tail_d      = tail_q;
    if (enq_fire) begin
      instr_mem_d[tail_q] = enq_instr_i;
      ld_mem_d[tail_q]    = enq_is_load_i;
      tail_d              = tail_q + PTR_W'(1);
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(issue);
    count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue);
    // Responses only clear a flag that is set; an issue can never coincide with a set flag.
    ld_busy_d = (ld_busy_q && !load_mem_resp_i) || (iss_valid && iss_is_load);
    st_busy_d = (st_busy_q && !store_mem_resp_i) || (iss_valid && !iss_is_load);
    st_addr_d = (iss_valid && !iss_is_load) ? iss_instr : st_addr_q;
    valid_out_d   = iss_valid;
    is_load_out_d = iss_valid && iss_is_load;
    instr_out_d   = iss_valid ? iss_instr : '0;
  end

  always_ff @(posedge clk_i) begin
    instr_mem_q <= instr_mem_d;
    ld_mem_q    <= ld_mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      ld_busy_q     <= 1'b0;
      st_busy_q     <= 1'b0;
      st_addr_q     <= '0;
      valid_out_q   <= 1'b0;
      is_load_out_q <= 1'b0;
      instr_out_q   <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      ld_busy_q     <= ld_busy_d;
      st_busy_q     <= st_busy_d;
      st_addr_q     <= st_addr_d;
      valid_out_q   <= valid_out_d;
      is_load_out_q <= is_load_out_d;
      instr_out_q   <= instr_out_d;
    end
  end

  assign instr_valid_o = valid_out_q;
  assign is_load_o     = is_load_out_q;
  assign instr_o       = instr_out_q;
  assign count_o       = count_q;

endmodule
